// File: rtl/sdram_arbiter_if.sv
// rtl/sdram_arbiter_if.sv - bundle of requester ports A/B and SDRAM controller handshake
interface sdram_arbiter_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 32
);
  // Port A (CPU bus)
  logic              a_req;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic [DATA_W-1:0] a_rdata;
  logic              a_ack;
  // Port B (video/DMA fetcher)
  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic [DATA_W-1:0] b_rdata;
  logic              b_ack;
  // Sticky abort flag
  logic              timeout_err;
  // Controller side
  logic              ctrl_init_done;
  logic              ctrl_busy;
  logic              ctrl_q_ready;
  logic [DATA_W-1:0] ctrl_q;
  logic              ctrl_start;
  logic              ctrl_we;
  logic [ADDR_W-1:0] ctrl_addr;
  logic [DATA_W-1:0] ctrl_d;

  // Environment view: requesters plus the controller model
  modport master (
    output a_req, a_we, a_addr, a_wdata,
    input  a_rdata, a_ack,
    output b_req, b_we, b_addr, b_wdata,
    input  b_rdata, b_ack,
    input  timeout_err,
    output ctrl_init_done, ctrl_busy, ctrl_q_ready, ctrl_q,
    input  ctrl_start, ctrl_we, ctrl_addr, ctrl_d
  );

  // Arbiter view
  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    output a_rdata, a_ack,
    input  b_req, b_we, b_addr, b_wdata,
    output b_rdata, b_ack,
    output timeout_err,
    input  ctrl_init_done, ctrl_busy, ctrl_q_ready, ctrl_q,
    output ctrl_start, ctrl_we, ctrl_addr, ctrl_d
  );
endinterface

// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - two-port round-robin arbiter and handshake bridge to the SDRAM controller
module sdram_arbiter #(
  parameter int ADDR_W  = 24,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1023
) (
  input logic           clk,
  input logic           reset,
  sdram_arbiter_if.slave bus
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  // Last timer value before the abort fires: the abort lands on the TIMEOUT-th ISSUE cycle
  localparam logic [TW-1:0] TMAX = TW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  typedef enum logic [2:0] {
    S_WAIT_INIT,
    S_IDLE,
    S_ISSUE,
    S_DONE,
    S_DRAIN
  } state_t;

  state_t            r_state, w_state_nxt;
  logic              r_last_grant, w_last_grant_nxt;  // 0 = A, 1 = B
  logic              r_gnt, w_gnt_nxt;                // port currently being served
  logic [TW-1:0]     r_timer, w_timer_nxt;
  logic              r_q_ready_d;
  logic              r_ctrl_start, w_ctrl_start_nxt;
  logic              r_ctrl_we, w_ctrl_we_nxt;
  logic [ADDR_W-1:0] r_ctrl_addr, w_ctrl_addr_nxt;
  logic [DATA_W-1:0] r_ctrl_d, w_ctrl_d_nxt;
  logic [DATA_W-1:0] r_a_rdata, w_a_rdata_nxt;
  logic [DATA_W-1:0] r_b_rdata, w_b_rdata_nxt;
  logic              r_a_ack, w_a_ack_nxt;
  logic              r_b_ack, w_b_ack_nxt;
  logic              r_timeout_err, w_timeout_err_nxt;

  logic              w_q_rise;
  logic              w_pick_b;
  logic              w_finish;
  logic              w_unused_busy;

  // Busy is diagnostic only; the handshake relies solely on q_ready
  assign w_unused_busy = bus.ctrl_busy;

  assign w_q_rise = bus.ctrl_q_ready & ~r_q_ready_d;
  // B wins when it is alone, or when both request and A was served last
  assign w_pick_b = bus.b_req & (~bus.a_req | ~r_last_grant);

  // State register and all registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_WAIT_INIT;
      r_last_grant  <= 1'b1;
      r_gnt         <= 1'b0;
      r_timer       <= '0;
      r_q_ready_d   <= 1'b0;
      r_ctrl_start  <= 1'b0;
      r_ctrl_we     <= 1'b0;
      r_ctrl_addr   <= '0;
      r_ctrl_d      <= '0;
      r_a_rdata     <= '0;
      r_b_rdata     <= '0;
      r_a_ack       <= 1'b0;
      r_b_ack       <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_last_grant  <= w_last_grant_nxt;
      r_gnt         <= w_gnt_nxt;
      r_timer       <= w_timer_nxt;
      r_q_ready_d   <= bus.ctrl_q_ready;
      r_ctrl_start  <= w_ctrl_start_nxt;
      r_ctrl_we     <= w_ctrl_we_nxt;
      r_ctrl_addr   <= w_ctrl_addr_nxt;
      r_ctrl_d      <= w_ctrl_d_nxt;
      r_a_rdata     <= w_a_rdata_nxt;
      r_b_rdata     <= w_b_rdata_nxt;
      r_a_ack       <= w_a_ack_nxt;
      r_b_ack       <= w_b_ack_nxt;
      r_timeout_err <= w_timeout_err_nxt;
    end
  end

  // Next-state and output decode; acks default low so they only ever pulse
  always_comb begin
    w_state_nxt       = r_state;
    w_last_grant_nxt  = r_last_grant;
    w_gnt_nxt         = r_gnt;
    w_timer_nxt       = r_timer;
    w_ctrl_start_nxt  = r_ctrl_start;
    w_ctrl_we_nxt     = r_ctrl_we;
    w_ctrl_addr_nxt   = r_ctrl_addr;
    w_ctrl_d_nxt      = r_ctrl_d;
    w_a_rdata_nxt     = r_a_rdata;
    w_b_rdata_nxt     = r_b_rdata;
    w_a_ack_nxt       = 1'b0;
    w_b_ack_nxt       = 1'b0;
    w_timeout_err_nxt = r_timeout_err;
    w_finish          = 1'b0;

    case (r_state)
      S_WAIT_INIT: begin
        if (bus.ctrl_init_done) w_state_nxt = S_IDLE;
      end

      S_IDLE: begin
        if (bus.a_req || bus.b_req) begin
          w_gnt_nxt        = w_pick_b;
          w_ctrl_we_nxt    = w_pick_b ? bus.b_we    : bus.a_we;
          w_ctrl_addr_nxt  = w_pick_b ? bus.b_addr  : bus.a_addr;
          w_ctrl_d_nxt     = w_pick_b ? bus.b_wdata : bus.a_wdata;
          w_ctrl_start_nxt = 1'b1;
          w_timer_nxt      = '0;
          w_state_nxt      = S_ISSUE;
        end
      end

      S_ISSUE: begin
        if (w_q_rise) begin
          w_finish = 1'b1;
          if (!r_ctrl_we) begin
            if (r_gnt) w_b_rdata_nxt = bus.ctrl_q;
            else       w_a_rdata_nxt = bus.ctrl_q;
          end
        end else if ((TIMEOUT != 0) && (r_timer == TMAX)) begin
          // Abort with zero data so the requesting bus cannot deadlock
          w_finish          = 1'b1;
          w_timeout_err_nxt = 1'b1;
          if (r_gnt) w_b_rdata_nxt = '0;
          else       w_a_rdata_nxt = '0;
        end else begin
          w_timer_nxt = r_timer + TW'(1);
        end
        if (w_finish) begin
          w_ctrl_start_nxt = 1'b0;
          w_a_ack_nxt      = ~r_gnt;
          w_b_ack_nxt      = r_gnt;
          w_last_grant_nxt = r_gnt;
          w_state_nxt      = S_DONE;
        end
      end

      // Never re-arbitrate while the previous access's q_ready level is still up
      S_DONE, S_DRAIN: begin
        w_state_nxt = bus.ctrl_q_ready ? S_DRAIN : S_IDLE;
      end

      default: w_state_nxt = S_WAIT_INIT;
    endcase
  end

  assign bus.ctrl_start  = r_ctrl_start;
  assign bus.ctrl_we     = r_ctrl_we;
  assign bus.ctrl_addr   = r_ctrl_addr;
  assign bus.ctrl_d      = r_ctrl_d;
  assign bus.a_rdata     = r_a_rdata;
  assign bus.b_rdata     = r_b_rdata;
  assign bus.a_ack       = r_a_ack;
  assign bus.b_ack       = r_b_ack;
  assign bus.timeout_err = r_timeout_err;

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb/tb_sdram_arbiter.sv - directed self-checking bench for sdram_arbiter
module tb_sdram_arbiter;
  localparam int ADDR_W = 24;
  localparam int DATA_W = 32;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;
  int   viol;
  logic prev_start;

  sdram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sdram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(15)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Flags a fresh start issued while q_ready is still high
  always @(negedge clk) begin
    prev_start <= bus.ctrl_start;
    if (bus.ctrl_start && !prev_start && bus.ctrl_q_ready) viol <= viol + 1;
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_start(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < max_cyc; k++) begin
      if (bus.ctrl_start) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  initial begin
    int bad;
    bit ok;
    logic [31:0] exp_data;
    n_tests = 0;
    n_fail  = 0;
    viol    = 0;
    prev_start = 1'b0;
    reset = 1'b1;
    bus.a_req = 0; bus.a_we = 0; bus.a_addr = '0; bus.a_wdata = '0;
    bus.b_req = 0; bus.b_we = 0; bus.b_addr = '0; bus.b_wdata = '0;
    bus.ctrl_init_done = 0; bus.ctrl_busy = 0; bus.ctrl_q_ready = 0; bus.ctrl_q = '0;
    @(negedge clk);
    tick();
    tick();

    // Reset state
    chk("rst_start", bus.ctrl_start, 0);
    chk("rst_a_ack", bus.a_ack, 0);
    chk("rst_b_ack", bus.b_ack, 0);
    chk("rst_a_rdata", bus.a_rdata, 0);
    chk("rst_b_rdata", bus.b_rdata, 0);
    chk("rst_terr", bus.timeout_err, 0);
    reset = 1'b0;

    // Requests ignored before init completes
    bus.a_req = 1; bus.a_we = 1; bus.a_addr = 24'h000010; bus.a_wdata = 32'hDEADBEEF;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (bus.ctrl_start) bad++;
    end
    chk("init_no_start", bad, 0);
    bus.ctrl_init_done = 1;
    tick();
    chk("init_idle_cycle", bus.ctrl_start, 0);
    tick();
    chk("a_wr_start", bus.ctrl_start, 1);
    chk("a_wr_addr", bus.ctrl_addr, 24'h000010);
    chk("a_wr_we", bus.ctrl_we, 1);
    chk("a_wr_d", bus.ctrl_d, 32'hDEADBEEF);

    // Port inputs change mid-access; controller side must hold
    bus.a_addr = 24'hFFFFFF; bus.a_wdata = 32'h0; bus.a_we = 0;
    bad = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (!bus.ctrl_start || bus.ctrl_addr !== 24'h000010 ||
          bus.ctrl_d !== 32'hDEADBEEF || bus.ctrl_we !== 1'b1 || bus.a_ack) bad++;
    end
    chk("a_wr_hold", bad, 0);
    bus.ctrl_q_ready = 1;
    tick();
    chk("a_wr_ack", bus.a_ack, 1);
    chk("a_wr_b_ack", bus.b_ack, 0);
    chk("a_wr_start_drop", bus.ctrl_start, 0);
    bus.a_req = 0;
    tick();
    chk("a_wr_ack_pulse", bus.a_ack, 0);

    // Port B read queued while stale q_ready is still high
    bus.b_req = 1; bus.b_we = 0; bus.b_addr = 24'h123456;
    bad = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (bus.ctrl_start) bad++;
    end
    chk("drain_no_start", bad, 0);
    bus.ctrl_q_ready = 0;
    tick();
    chk("drain_idle_cycle", bus.ctrl_start, 0);
    tick();
    chk("b_rd_start", bus.ctrl_start, 1);
    chk("b_rd_addr", bus.ctrl_addr, 24'h123456);
    chk("b_rd_we", bus.ctrl_we, 0);
    bus.ctrl_q = 32'hCAFEF00D;
    for (int i = 0; i < 3; i++) tick();
    bus.ctrl_q_ready = 1;
    tick();
    chk("b_rd_ack", bus.b_ack, 1);
    chk("b_rd_data", bus.b_rdata, 32'hCAFEF00D);
    chk("b_rd_a_ack", bus.a_ack, 0);
    chk("a_rdata_kept", bus.a_rdata, 0);
    bus.b_req = 0;
    bus.ctrl_q_ready = 0;
    tick();
    chk("b_rd_ack_pulse", bus.b_ack, 0);

    // Both ports requesting continuously: A, B, A, B
    bus.a_req = 1; bus.a_we = 0; bus.a_addr = 24'h00000A;
    bus.b_req = 1; bus.b_we = 0; bus.b_addr = 24'h00000B;
    for (int i = 0; i < 4; i++) begin
      wait_start(10, ok);
      chk("rr_start_seen", ok, 1);
      chk("rr_grant", bus.ctrl_addr, (i % 2 == 0) ? 24'h00000A : 24'h00000B);
      exp_data = 32'h11110000 + 32'(i);
      bus.ctrl_q = exp_data;
      tick();
      tick();
      bus.ctrl_q_ready = 1;
      tick();
      if (i % 2 == 0) begin
        chk("rr_a_ack", {bus.a_ack, bus.b_ack}, 2'b10);
        chk("rr_a_data", bus.a_rdata, exp_data);
      end else begin
        chk("rr_b_ack", {bus.a_ack, bus.b_ack}, 2'b01);
        chk("rr_b_data", bus.b_rdata, exp_data);
      end
      tick();
      bus.ctrl_q_ready = 0;
    end
    bus.a_req = 0;
    bus.b_req = 0;
    tick();
    chk("rr_no_stale_start", viol, 0);

    // Timeout abort after 15 ISSUE cycles
    tick();
    bus.a_req = 1; bus.a_we = 0; bus.a_addr = 24'h000055;
    wait_start(10, ok);
    chk("to_start_seen", ok, 1);
    for (int i = 0; i < 14; i++) tick();
    chk("to_still_waiting", {bus.ctrl_start, bus.a_ack, bus.timeout_err}, 3'b100);
    tick();
    chk("to_start_drop", bus.ctrl_start, 0);
    chk("to_err", bus.timeout_err, 1);
    chk("to_a_ack", bus.a_ack, 1);
    chk("to_a_rdata", bus.a_rdata, 0);
    bus.a_req = 0;
    for (int i = 0; i < 5; i++) tick();
    chk("to_err_sticky", bus.timeout_err, 1);

    // Reset in the middle of an access
    bus.a_req = 1; bus.a_we = 1; bus.a_addr = 24'h000077; bus.a_wdata = 32'h12345678;
    wait_start(10, ok);
    chk("rst_mid_start_seen", ok, 1);
    tick();
    tick();
    reset = 1;
    bus.ctrl_init_done = 0;
    tick();
    chk("rst_mid_start", bus.ctrl_start, 0);
    chk("rst_mid_acks", {bus.a_ack, bus.b_ack}, 2'b00);
    chk("rst_mid_err", bus.timeout_err, 0);
    reset = 0;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.ctrl_start) bad++;
    end
    chk("rst_mid_wait_init", bad, 0);
    bus.ctrl_init_done = 1;
    tick();
    tick();
    chk("post_rst_start", bus.ctrl_start, 1);
    chk("post_rst_addr", bus.ctrl_addr, 24'h000077);
    chk("post_rst_d", bus.ctrl_d, 32'h12345678);
    bus.ctrl_q_ready = 1;
    tick();
    chk("post_rst_ack", bus.a_ack, 1);
    bus.a_req = 0;
    bus.ctrl_q_ready = 0;
    tick();
    chk("post_rst_ack_pulse", bus.a_ack, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
